// File: rtl/div_pkg.sv
// Shared encodings for the iterative 32-bit divider: FSM states and the
// ready/start handshake levels.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam int unsigned DivWidth = 32;

endpackage

// File: rtl/div.sv
// Multi-cycle signed/unsigned 32-bit restoring divider, one quotient bit per
// cycle, result packed as {remainder, quotient}.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q;      // dividend bits shift out the top, quotient bits shift in
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic        neg_quo_q;
  logic        neg_rem_q;

  logic [32:0] partial;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] quo_next;
  logic [31:0] rem_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        accept;

  assign accept = (start_i == DivStart) && !annul_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DivFree;
    else      state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DivFree:   if (accept) state_d = (opdata2_i == '0) ? DivByZero : DivOn;
      DivByZero: state_d = DivEnd;
      DivOn: begin
        if (annul_i)              state_d = DivFree;
        else if (cnt_q == 5'd31)  state_d = DivEnd;
      end
      DivEnd:    if (start_i == DivStop) state_d = DivFree;
    endcase
  end

  // 33-bit trial subtract: the borrow bit decides the quotient bit and
  // whether the shifted partial remainder is restored.
  always_comb begin
    partial  = {rem_q, quo_q[31]};
    diff     = partial - {1'b0, dvs_q};
    q_bit    = ~diff[32];
    rem_next = q_bit ? diff[31:0] : partial[31:0];
    quo_next = {quo_q[30:0], q_bit};
    quo_fix  = neg_quo_q ? (~quo_next + 32'd1) : quo_next;
    rem_fix  = neg_rem_q ? (~rem_next + 32'd1) : rem_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_o   <= DivResultNotReady;
      result_o  <= '0;
    end else begin
      case (state_q)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          cnt_q    <= '0;
          if (accept && opdata2_i != '0) begin
            // Capture magnitudes; 0x80000000 negates to itself, i.e. unsigned 2^31.
            quo_q     <= (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
            dvs_q     <= (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
            rem_q     <= '0;
            neg_quo_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_q <= signed_div_i && opdata1_i[31];
          end
        end
        DivByZero: begin
          quo_q <= '0;
          rem_q <= '0;
        end
        DivOn: begin
          if (annul_i) begin
            cnt_q <= '0;
          end else if (cnt_q == 5'd31) begin
            quo_q <= quo_fix;
            rem_q <= rem_fix;
            cnt_q <= '0;
          end else begin
            quo_q <= quo_next;
            rem_q <= rem_next;
            cnt_q <= cnt_q + 5'd1;
          end
        end
        DivEnd: begin
          if (start_i == DivStart) begin
            ready_o  <= DivResultReady;
            result_o <= {rem_q, quo_q};
          end else begin
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the divider: expected results are queued at drive time
// and compared when ready_o rises, along with latency, hold, annul and reset.
module tb_div;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic        na, nb;
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    na = sg & a[31];
    nb = sg & b[31];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = -q;
    if (na)      r = -r;
    return {r, q};
  endfunction

  // Wait up to 'limit' edges for ready_o; returns the edge count seen.
  task automatic wait_ready(input int limit, output int edges);
    edges = 0;
    while (edges < limit) begin
      @(posedge clk); #1;
      edges++;
      if (ready_o) break;
    end
  endtask

  task automatic run_div(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int          edges;
    sb.push_back(model(sg, a, b));
    @(negedge clk);
    signed_div_i = sg; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    // Disturb operands after acceptance; the result must not change.
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sg;
    check({tag, "_busy"}, 64'(ready_o), 64'd0);
    wait_ready(60, edges);
    check({tag, "_latency"}, 64'(edges), (b == 32'd0) ? 64'd2 : 64'd33);
    exp = sb.pop_front();
    check({tag, "_result"}, result_o, exp);
    @(posedge clk); #1;
    check({tag, "_hold"}, {63'd0, ready_o} ^ 64'd1 | result_o ^ exp, 64'd0);
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    int          edges;
    int          seen;
    logic [31:0] ra, rb;
    logic [63:0] exp;

    #12;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready", 64'(ready_o), 64'd0);
    check("idle_state", 64'(dut.state_q), 64'(DivFree));

    run_div("u100_7",     1'b0, 32'd100,        32'd7);
    run_div("s_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2);
    run_div("u5_0",       1'b0, 32'd5,          32'd0);
    run_div("s_min_0",    1'b1, 32'h8000_0000,  32'd0);
    run_div("s_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF);
    run_div("u_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1);
    run_div("u_min_max",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF);
    run_div("s7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom >> $urandom_range(0, 28);
      run_div($sformatf("rand%0d", i), i[0], ra, rb);
    end

    // Annul at iteration 10.
    @(negedge clk); signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_state", 64'(dut.state_q), 64'(DivFree));
    check("annul_cnt", 64'(dut.cnt_q), 64'd0);
    @(negedge clk); annul_i = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) seen++; end
    check("annul_no_ready", 64'(seen), 64'd0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3);

    // Reset asserted between edges at iteration 20.
    @(negedge clk); opdata1_i = 32'd1234567; opdata2_i = 32'd89; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2 rst = 1'b0; start_i = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    check("rst_mid_state", 64'(dut.state_q), 64'(DivFree));
    check("rst_mid_cnt", 64'(dut.cnt_q), 64'd0);
    @(negedge clk); rst = 1'b1;
    run_div("u50_5", 1'b0, 32'd50, 32'd5);

    // Reset while a result is being held.
    sb.push_back(model(1'b0, 32'd778, 32'd7));
    @(negedge clk); opdata1_i = 32'd778; opdata2_i = 32'd7; start_i = 1'b1;
    wait_ready(60, edges);
    exp = sb.pop_front();
    check("end_result", result_o, exp);
    #2 rst = 1'b0; start_i = 1'b0;
    #1;
    check("rst_end_ready", 64'(ready_o), 64'd0);
    check("rst_end_result", result_o, 64'd0);
    @(negedge clk); rst = 1'b1;
    run_div("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
